// File: rtl/multiboot_pkg.sv
// multiboot_pkg
//   Shared definitions for the multiboot warm-boot sequencer: the controller
//   state encoding, the ICAPE2 IPROG command words, the sequence geometry and
//   the helpers that build the word presented on the ICAP bus.
package multiboot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SEND,
      RELEASE,
      DONE
   } state_e;

   localparam logic [31:0] DUMMY     = 32'hFFFF_FFFF;
   localparam logic [31:0] SYNC      = 32'hAA99_5566;
   localparam logic [31:0] NOOP      = 32'h2000_0000;
   localparam logic [31:0] WR_WBSTAR = 32'h3002_0001;
   localparam logic [31:0] WR_CMD    = 32'h3000_8001;
   localparam logic [31:0] CMD_IPROG = 32'h0000_000F;

   localparam int SEQ_LEN     = 8;
   localparam int WBSTAR_SLOT = 4;

   // ICAPE2 expects each byte of its data bus bit-reversed relative to the
   // configuration-packet byte order.
   function automatic logic [31:0] bitswap32(input logic [31:0] w);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            r[8*b+i] = w[8*b+7-i];
         end
      end
      return r;
   endfunction

   // Word k of the IPROG sequence; the WBSTAR slot carries the chosen image.
   function automatic logic [31:0] seq_word(input logic [2:0] k,
                                            input logic [31:0] wbstar);
      logic [31:0] w;
      case (k)
         3'd0:    w = DUMMY;
         3'd1:    w = SYNC;
         3'd2:    w = NOOP;
         3'd3:    w = WR_WBSTAR;
         3'd4:    w = wbstar;
         3'd5:    w = WR_CMD;
         3'd6:    w = CMD_IPROG;
         default: w = NOOP;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/boot_debounce.sv
// boot_debounce
//   Saturating counter of consecutive high cycles on req_i. pulse_o is high
//   for exactly the one cycle in which the count reaches DEBOUNCE_CYCLES;
//   holding the request longer does not re-fire, any low cycle re-arms.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   req_i   synchronous level request
//   pulse_o one-cycle trigger pulse
module boot_debounce #(
   parameter int DEBOUNCE_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_i,
   output logic pulse_o
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] MAX = CW'(DEBOUNCE_CYCLES);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (req_i) begin
         cnt_d = (cnt_q == MAX) ? cnt_q : cnt_q + CW'(1);
      end
   end

   // Fires only on the transition into saturation.
   assign pulse_o = (cnt_d == MAX) && (cnt_q != MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/multiboot_sequencer.sv
// multiboot_sequencer
//   Warm-boot controller: debounces a boot request (or fires an auto-boot
//   timeout that DFU activity cancels), selects one of NUM_IMAGES WBSTAR
//   addresses and drives the ICAPE2 IPROG sequence one word per clock.
// Ports:
//   clk         system clock (also the ICAPE2 clock)
//   reset       asynchronous active-low reset
//   boot_req    level boot request (button)
//   image_sel   image index, sampled at trigger
//   dfu_active  DFU transfer in progress; permanently cancels auto-boot
//   boot_busy   high from trigger until DONE
//   boot_done   high in DONE (terminal until reset)
//   sel_error   sticky: out-of-range image_sel replaced by image 0
//   icap_csib   ICAPE2 CSIB (active-low)
//   icap_rdwrb  ICAPE2 RDWRB (0 = write)
//   icap_data   ICAPE2 I bus
module multiboot_sequencer
   import multiboot_pkg::*;
#(
   parameter int                       NUM_IMAGES      = 2,
   parameter int                       IDX_W           = 4,
   parameter logic [NUM_IMAGES*32-1:0] IMAGE_ADDRS     = {32'h0200_0000, 32'h0000_0000},
   parameter int                       DEBOUNCE_CYCLES = 65535,
   parameter int                       AUTOBOOT_CYCLES = 0,
   parameter int                       AUTOBOOT_IMAGE  = 1,
   parameter int                       BITSWAP         = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             boot_req,
   input  logic [IDX_W-1:0] image_sel,
   input  logic             dfu_active,
   output logic             boot_busy,
   output logic             boot_done,
   output logic             sel_error,
   output logic             icap_csib,
   output logic             icap_rdwrb,
   output logic [31:0]      icap_data
);

   localparam int AW = (AUTOBOOT_CYCLES > 0) ? $clog2(AUTOBOOT_CYCLES + 1) : 1;
   localparam logic [AW-1:0] AUTO_MAX = AW'(AUTOBOOT_CYCLES);

   state_e          state_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            csib_q;
   logic            rdwrb_q;
   logic [31:0]     data_q;
   logic [2:0]      idx_q;
   logic [31:0]     wbstar_q;
   logic [AW-1:0]   auto_cnt_q;
   logic [AW-1:0]   auto_cnt_d;
   logic            auto_dis_q;
   logic            auto_dis_d;

   logic            deb_pulse;
   logic            btn_trig;
   logic            auto_trig;
   logic            trig;
   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] use_idx;
   logic            idx_bad;
   logic [31:0]     wbstar_sel;

   boot_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk    (clk),
      .rst_n  (reset),
      .req_i  (boot_req),
      .pulse_o(deb_pulse)
   );

   function automatic logic [31:0] icap_word(input logic [2:0] k,
                                             input logic [31:0] wbstar);
      logic [31:0] w;
      w = seq_word(k, wbstar);
      return (BITSWAP != 0) ? bitswap32(w) : w;
   endfunction

   // Auto-boot timer only advances while waiting in IDLE; one DFU cycle
   // disables it for the rest of this reset epoch.
   always_comb begin
      auto_cnt_d = auto_cnt_q;
      auto_dis_d = auto_dis_q;
      if (state_q == IDLE) begin
         if (dfu_active) begin
            auto_cnt_d = '0;
            auto_dis_d = 1'b1;
         end else if (auto_cnt_q != AUTO_MAX) begin
            auto_cnt_d = auto_cnt_q + AW'(1);
         end
      end
   end

   assign btn_trig  = deb_pulse && (state_q == IDLE);
   assign auto_trig = (AUTOBOOT_CYCLES != 0) && (state_q == IDLE) && !auto_dis_q &&
                      !dfu_active && (auto_cnt_d == AUTO_MAX) && (auto_cnt_q != AUTO_MAX);
   assign trig      = btn_trig || auto_trig;

   // Button has priority over auto-boot when both fire together.
   always_comb begin
      req_idx    = btn_trig ? image_sel : IDX_W'(AUTOBOOT_IMAGE);
      idx_bad    = int'(req_idx) >= NUM_IMAGES;
      use_idx    = idx_bad ? '0 : req_idx;
      wbstar_sel = IMAGE_ADDRS[31:0];
      for (int i = 0; i < NUM_IMAGES; i++) begin
         if (int'(use_idx) == i) begin
            wbstar_sel = IMAGE_ADDRS[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         csib_q     <= 1'b1;
         rdwrb_q    <= 1'b1;
         data_q     <= DUMMY;
         idx_q      <= '0;
         wbstar_q   <= '0;
         auto_cnt_q <= '0;
         auto_dis_q <= 1'b0;
      end else begin
         auto_cnt_q <= auto_cnt_d;
         auto_dis_q <= auto_dis_d;
         case (state_q)
            IDLE: begin
               if (trig) begin
                  state_q  <= ARM;
                  busy_q   <= 1'b1;
                  rdwrb_q  <= 1'b0;
                  wbstar_q <= wbstar_sel;
                  if (idx_bad) begin
                     err_q <= 1'b1;
                  end
               end
            end
            // rdwrb already settled low while csib is still high.
            ARM: begin
               state_q <= SEND;
               csib_q  <= 1'b0;
               idx_q   <= 3'd0;
               data_q  <= icap_word(3'd0, wbstar_q);
            end
            // idx_q is the index of the word currently on the bus.
            SEND: begin
               if (idx_q == 3'(SEQ_LEN - 1)) begin
                  state_q <= RELEASE;
                  csib_q  <= 1'b1;
                  data_q  <= DUMMY;
               end else begin
                  idx_q  <= idx_q + 3'd1;
                  data_q <= icap_word(idx_q + 3'd1, wbstar_q);
               end
            end
            RELEASE: begin
               state_q <= DONE;
               rdwrb_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               data_q  <= DUMMY;
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign boot_busy  = busy_q;
   assign boot_done  = done_q;
   assign sel_error  = err_q;
   assign icap_csib  = csib_q;
   assign icap_rdwrb = rdwrb_q;
   assign icap_data  = data_q;

endmodule
